// File: rtl/crc8_pkg.sv
// Shared CRC-8 constants, checker state encoding and the single-bit CRC step.
// Used by both the receive-side checker and the write-path generator.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h31;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_SHIFT,
        ST_WAIT_CRC
    } chk_state_e;

    // One MSB-first shift of the CRC register with conditional polynomial feedback.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] poly);
        return {crc[6:0], 1'b0} ^ (crc[7] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial_core.sv
// Bit-serial CRC-8 engine: an 8-bit CRC register plus a 3-bit step counter.
// Priority of controls: load_init, then xor_byte, then step.
module crc8_serial_core
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_init,
    input  logic       xor_byte,
    input  logic [7:0] byte_in,
    input  logic       step,
    output logic [7:0] crc,
    output logic       done
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [2:0] step_cnt_q;
    logic [2:0] step_cnt_d;

    always_comb begin
        crc_d      = crc_q;
        step_cnt_d = step_cnt_q;
        if (load_init) begin
            crc_d      = INIT;
            step_cnt_d = 3'd0;
        end else if (xor_byte) begin
            crc_d      = crc_q ^ byte_in;
            step_cnt_d = 3'd0;
        end else if (step) begin
            crc_d      = crc8_step(crc_q, POLY);
            step_cnt_d = step_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q      <= INIT;
            step_cnt_q <= 3'd0;
        end else begin
            crc_q      <= crc_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign crc  = crc_q;
    // High during the eighth shift, so the caller leaves SHIFT on that edge.
    assign done = step && (step_cnt_q == 3'd7);

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 checker for 2-data-byte + 1-CRC-byte sensor words, with frame status.
// Optional saturating mismatch counter on port err_cnt when CRC_ERR_CNT_EN is defined.
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter int         WORDS_PER_FRAME = 2,
    parameter logic [7:0] POLY            = CRC8_POLY,
    parameter logic [7:0] INIT            = CRC8_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        byte_ready,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        frame_done,
    output logic        frame_err
`ifdef CRC_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [4:0] LAST_WORD = 5'(WORDS_PER_FRAME - 1);

    chk_state_e  state_q;
    logic        byte_ready_q;
    logic        lo_phase_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic [15:0] word_q;
    logic        word_valid_q;
    logic        crc_ok_q;
    logic        crc_err_q;
    logic        frame_done_q;
    logic        frame_err_q;
    logic        frame_acc_q;
    logic [4:0]  word_cnt_q;

    logic        hs;
    logic        in_wait_data;
    logic        crc_mismatch;
    logic        core_load;
    logic        core_xor;
    logic        core_step;
    logic        core_done;
    logic [7:0]  core_crc;

    assign hs           = byte_valid && byte_ready_q;
    assign in_wait_data = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
    assign crc_mismatch = (byte_in != core_crc);

    // The received CRC byte is only compared, never fed into the engine.
    assign core_load = abort || (state_q == ST_INIT) || ((state_q == ST_WAIT_CRC) && hs);
    assign core_xor  = !abort && in_wait_data && hs;
    assign core_step = !abort && (state_q == ST_SHIFT);

    crc8_serial_core #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load_init (core_load),
        .xor_byte  (core_xor),
        .byte_in   (byte_in),
        .step      (core_step),
        .crc       (core_crc),
        .done      (core_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            byte_ready_q <= 1'b0;
            lo_phase_q   <= 1'b0;
            hi_q         <= 8'h00;
            lo_q         <= 8'h00;
            word_q       <= 16'h0000;
            word_valid_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            crc_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_acc_q  <= 1'b0;
            word_cnt_q   <= 5'd0;
        end else begin
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (abort) begin
                state_q      <= ST_WAIT_HI;
                byte_ready_q <= 1'b1;
                lo_phase_q   <= 1'b0;
                word_cnt_q   <= 5'd0;
                frame_acc_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        state_q      <= ST_WAIT_HI;
                        byte_ready_q <= 1'b1;
                        lo_phase_q   <= 1'b0;
                        word_cnt_q   <= 5'd0;
                        frame_acc_q  <= 1'b0;
                    end
                    ST_WAIT_HI: begin
                        if (hs) begin
                            hi_q         <= byte_in;
                            lo_phase_q   <= 1'b0;
                            byte_ready_q <= 1'b0;
                            state_q      <= ST_SHIFT;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (hs) begin
                            lo_q         <= byte_in;
                            lo_phase_q   <= 1'b1;
                            byte_ready_q <= 1'b0;
                            state_q      <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (core_done) begin
                            byte_ready_q <= 1'b1;
                            state_q      <= lo_phase_q ? ST_WAIT_CRC : ST_WAIT_LO;
                        end
                    end
                    ST_WAIT_CRC: begin
                        if (hs) begin
                            word_q       <= {hi_q, lo_q};
                            word_valid_q <= 1'b1;
                            crc_ok_q     <= !crc_mismatch;
                            crc_err_q    <= crc_mismatch;
                            state_q      <= ST_WAIT_HI;
                            if (word_cnt_q == LAST_WORD) begin
                                frame_done_q <= 1'b1;
                                frame_err_q  <= frame_acc_q | crc_mismatch;
                                frame_acc_q  <= 1'b0;
                                word_cnt_q   <= 5'd0;
                            end else begin
                                frame_acc_q  <= frame_acc_q | crc_mismatch;
                                word_cnt_q   <= word_cnt_q + 5'd1;
                            end
                        end
                    end
                    default: begin
                        state_q      <= ST_INIT;
                        byte_ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign byte_ready = byte_ready_q;
    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign crc_ok     = crc_ok_q;
    assign crc_err    = crc_err_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

`ifdef CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Survives abort; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else if (!abort && (state_q == ST_WAIT_CRC) && hs && crc_mismatch
                     && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/crc8_frame_checker.md
# crc8_frame_checker

Receive-side CRC-8 checker for sensor read frames on the I2C master data path. It consumes bytes delivered by the I2C byte receiver in the standard 2-data-byte + 1-CRC-byte word format, using CRC-8 with polynomial 0x31, init 0xFF and no final XOR. It recomputes each word's CRC bit-serially, compares it against the received CRC byte, and emits the 16-bit word with a pass/fail flag. It also reports a frame-level status after a configurable number of words.

## Interface
- WORDS_PER_FRAME, 2: words (3-byte groups) per frame; legal range 1..16.
- POLY, 8'h31: CRC polynomial.
- INIT, 8'hFF: CRC seed, reloaded at the start of every word.

- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- abort  input  1  discard any partial word or frame, return to first-byte wait.
- byte_valid  input  1  byte_in holds a received byte.
- byte_in  input  8  received byte, MSB first within the word.
- byte_ready  output  1  checker can accept a byte this cycle.
- word_out  output  16  {hi byte, lo byte} of the last completed word.
- word_valid  output  1  one-cycle pulse: word_out, crc_ok and crc_err are updated.
- crc_ok  output  1  last word's CRC matched.
- crc_err  output  1  last word's CRC mismatched.
- frame_done  output  1  one-cycle pulse with the last word_valid of a frame.
- frame_err  output  1  at least one word in the completed frame failed; held until the next frame_done.
- err_cnt  output  8  saturating mismatch counter (only with CRC_ERR_CNT_EN).

## Operation
- States: INIT, WAIT_HI, WAIT_LO, SHIFT, WAIT_CRC.
- INIT: crc←INIT, byte index and word counter cleared. Always goes to WAIT_HI next cycle.
- WAIT_HI / WAIT_LO:
  - byte_ready=1.
  - On handshake: store the byte (hi or lo), crc←crc^byte_in, bit counter←0, go to SHIFT.
- SHIFT:
  - byte_ready=0, exactly 8 cycles.
  - Each cycle: crc←{crc[6:0],0} ^ (crc[7] ? POLY : 0).
  - After the 8th step, go to WAIT_LO (after hi) or WAIT_CRC (after lo).
- WAIT_CRC:
  - byte_ready=1.
  - On handshake: crc_ok←(byte_in==crc), crc_err←!crc_ok, word_out←{hi,lo}, word_valid pulse.
  - Then: crc←INIT, word counter+1, go to WAIT_HI.
- Frame end: when the word counter reaches WORDS_PER_FRAME, frame_done pulses, frame_err←OR of that frame's errors, and the counter wraps to 0.
- The CRC byte itself is never shifted through the CRC engine.
- abort:
  - Has priority over byte_valid in the same cycle.
  - Next state is WAIT_HI, crc←INIT, word counter←0, accumulated frame error cleared.
  - word_out, crc_ok, crc_err and frame_err keep their last values.
  - No pulse is generated.
- byte_valid while byte_ready=0 is ignored; the source must hold the byte until the handshake.
- Reset:
  - rst=0 at any cycle, including mid-SHIFT, forces INIT.
  - All outputs go to 0: word_out=16'h0000, word_valid, crc_ok, crc_err, frame_done and frame_err all 0, err_cnt=0.
  - byte_ready=0 during INIT.

## Timing
- Data byte accepted at edge N: byte_ready=0 for cycles N+1..N+8; byte_ready=1 again at N+9.
- Minimum word period is 9+9+1 = 19 cycles.
- CRC byte accepted at edge N: word_valid, crc_ok, crc_err and word_out are valid in cycle N+1. byte_ready is 1 in cycle N+1, so a new hi byte can be accepted back-to-back.
- All outputs are registered; there is no combinational path from byte_valid to byte_ready.
- word_valid and frame_done are high for exactly one cycle.

## Configuration
- CRC_ERR_CNT_EN defined: port err_cnt exists.
  - Increments by 1 on each word_valid with crc_err=1.
  - Saturates at 8'hFF and is cleared only by rst (not by abort).
- CRC_ERR_CNT_EN undefined: the port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package crc8_pkg holds:
  - CRC8_POLY=8'h31 and CRC8_INIT=8'hFF, shared with the CRC-8 generator on the write path.
  - The state enum (INIT, WAIT_HI, WAIT_LO, SHIFT, WAIT_CRC).
- One sub-module, crc8_serial_core:
  - Owns the 8-bit CRC register and the 3-bit step counter.
  - Inputs: load_init, xor_byte (with byte), step.
  - Outputs: crc, done.
  - The top-level FSM drives it.

## Test plan
- Word 0xBE, 0xEF, CRC 0x92, WORDS_PER_FRAME=1 → word_valid with word_out=16'hBEEF, crc_ok=1, crc_err=0, frame_done=1, frame_err=0.
- Same word with CRC byte 0x93 → crc_err=1, frame_err=1, err_cnt=1 (macro on).
- WORDS_PER_FRAME=2, byte sequence BE EF 92 BE EF 00 → two word_valid pulses (ok, then err); frame_done only on the second; frame_err=1.
- byte_valid held high during SHIFT → no extra byte consumed; each byte_ready gap is exactly 8 cycles.
- abort asserted after hi byte, then BE EF 92 → word_out=16'hBEEF, crc_ok=1, proving the CRC was reseeded.
- rst low mid-SHIFT, then released → byte_ready=0 for one cycle (INIT), outputs all 0, next full word checks correctly; 256 consecutive bad words → err_cnt saturates at 8'hFF.
